// File: rtl/wb_hyperram_arb_pkg.sv
// Shared types and defaults for the two-master HyperRAM Wishbone arbiter.
// Holds the FSM state enum, the master count and the default bus sizes.
package wb_hyperram_arb_pkg;

    localparam int NUM_MASTERS            = 2;
    localparam int DEFAULT_AW             = 32;
    localparam int DEFAULT_DW             = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [NUM_MASTERS-1:0] grant_of(arb_state_e s);
        logic [NUM_MASTERS-1:0] g;
        g = '0;
        if (s == OWN0) g = 2'b01;
        else if (s == OWN1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wb_hyperram_arb_rr_pick.sv
// Combinational round-robin pick: scans requesters starting just after the
// previous winner and returns a one-hot grant plus a valid flag.
module wb_hyperram_arb_rr_pick
    import wb_hyperram_arb_pkg::*;
#(
    parameter int N = NUM_MASTERS
) (
    input  logic [N-1:0]                         req_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last_i,
    output logic [N-1:0]                         gnt_o,
    output logic                                 valid_o
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [LW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = LW'((int'(last_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the HyperRAM slave; the
// grant is held for a whole cyc. Optional watchdog: WB_HYPERRAM_ARB_TIMEOUT_EN.
module wb_hyperram_arbiter
    import wb_hyperram_arb_pkg::*;
#(
    parameter int AW             = DEFAULT_AW,
    parameter int DW             = DEFAULT_DW,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0]   m_sel_i,
    input  logic [NUM_MASTERS*AW-1:0]       m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]       m_dat_i,
    output logic [DW-1:0]                   m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [DW/8-1:0]                 s_sel_o,
    output logic [AW-1:0]                   s_adr_o,
    output logic [DW-1:0]                   s_dat_o,
    input  logic [DW-1:0]                   s_dat_i,
    input  logic                            s_ack_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            busy_o
);

    localparam int SW = DW / 8;

    arb_state_e             state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic                   pick_is1;
    logic                   owned;
    logic                   owner;
    logic                   own_stb;
    logic                   tmo_fire;

    wb_hyperram_arb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_grant_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    assign pick_is1 = (pick_gnt == 2'b10);
    assign owned    = (state_q != IDLE);
    assign owner    = (state_q == OWN1);
    assign own_stb  = owned & m_cyc_i[owner] & m_stb_i[owner];

`ifdef WB_HYPERRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wdog_q, wdog_d;

    // An ack in the firing cycle rescues the transfer, so it masks the timeout.
    assign tmo_fire = owned & ~s_ack_i & (wdog_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        wdog_d = wdog_q;
        if (!owned || s_ack_i || tmo_fire) wdog_d = '0;
        else if (own_stb)                  wdog_d = wdog_q + 1'b1;
    end

    always_comb begin
        m_err_o = '0;
        if (tmo_fire) m_err_o[owner] = 1'b1;
    end
`else
    logic unused_timeout;

    assign tmo_fire       = 1'b0;
    assign m_err_o        = '0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = pick_is1 ? OWN1 : OWN0;
                    last_grant_d = pick_is1;
                end
            end
            OWN0, OWN1: begin
                if (!m_cyc_i[owner] || tmo_fire) begin
                    state_d      = IDLE;
                    last_grant_d = owner;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = grant_of(state_d);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= '0;
`ifdef WB_HYPERRAM_ARB_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
`ifdef WB_HYPERRAM_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (owned) begin
            s_cyc_o        = m_cyc_i[owner] & ~tmo_fire;
            s_stb_o        = own_stb & ~tmo_fire;
            s_we_o         = m_we_i[owner];
            s_sel_o        = m_sel_i[int'(owner)*SW +: SW];
            s_adr_o        = m_adr_i[int'(owner)*AW +: AW];
            s_dat_o        = m_dat_i[int'(owner)*DW +: DW];
            m_ack_o[owner] = s_ack_i;
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;
    assign busy_o  = owned;

endmodule
